// File: rtl/magic_streamer_pkg.sv
// rtl/magic_streamer_pkg.sv - shared encodings for the magic streamer sequencer
package magic_streamer_pkg;

  localparam logic [1:0] OP_STORE           = 2'd0;
  localparam logic [1:0] OP_LOAD            = 2'd1;
  localparam logic [1:0] OP_STORE_THEN_LOAD = 2'd2;
  localparam logic [1:0] OP_RESERVED        = 2'd3;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_EMPTY   = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;
  localparam logic [1:0] STATUS_BAD_OP  = 2'd3;

  localparam int CORE_IDLE  = 0;
  localparam int CORE_STORE = 1;
  localparam int CORE_LOAD  = 2;

  typedef enum logic [3:0] {
    IDLE,
    ST_RST,
    ST_INIT,
    ST_WAIT,
    LD_RST,
    LD_INIT,
    LD_ARM,
    LD_WAIT,
    RESP
  } seq_state_t;

endpackage

// File: rtl/ms_wait_timer.sv
// rtl/ms_wait_timer.sv - clear/enable wait counter with expiry flag (LIMIT 0 = never expires)
module ms_wait_timer #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  // expired flags the LIMIT-th consecutive enabled cycle
  assign expired = (LIMIT != '0) && en && (cnt == (LIMIT - 1'b1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/magic_streamer_sequencer.sv
// rtl/magic_streamer_sequencer.sv - command-driven store/replay sequencer for one streamer core
module magic_streamer_sequencer
  import magic_streamer_pkg::*;
#(
  parameter int                       STORAGE_IDX_WIDTH = 10,
  parameter int                       STATE_BIT_WIDTH   = 4,
  parameter int                       REPEAT_WIDTH      = 8,
  parameter int                       TIMEOUT_WIDTH     = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES    = 24'hFFFFFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [REPEAT_WIDTH-1:0]      cmd_repeat,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [1:0]                   resp_status,
  output logic [STORAGE_IDX_WIDTH:0]   resp_words,
  output logic                         busy,
  output logic                         core_store_reset,
  output logic                         core_store_init,
  output logic                         core_load_reset,
  output logic                         core_load_init,
  input  logic                         core_fin_store,
  input  logic [STATE_BIT_WIDTH-1:0]   core_state,
  input  logic [STORAGE_IDX_WIDTH:0]   core_store_words
);

  seq_state_t              state, state_next;
  logic [1:0]              op_q, op_next;
  logic [REPEAT_WIDTH-1:0] rep_cnt, rep_next;
  logic [1:0]              status_next;
  logic                    out_en;
  logic                    core_idle;
  logic                    in_wait;
  logic                    expired;

  assign core_idle  = (core_state == STATE_BIT_WIDTH'(CORE_IDLE));
  assign in_wait    = (state == ST_WAIT) || (state == LD_WAIT);
  // out_en keeps cmd_ready low while reset is held and until the first clock after release
  assign cmd_ready  = out_en && (state == IDLE) && core_idle;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  ms_wait_timer #(
    .WIDTH(TIMEOUT_WIDTH),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_wait),
    .en     (in_wait),
    .expired(expired)
  );

  always_comb begin
    state_next  = state;
    op_next     = op_q;
    rep_next    = rep_cnt;
    status_next = STATUS_OK;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_next  = cmd_op;
          rep_next = (cmd_repeat == '0) ? REPEAT_WIDTH'(1) : cmd_repeat;
          case (cmd_op)
            OP_LOAD:     state_next = LD_RST;
            OP_RESERVED: begin
              state_next  = RESP;
              status_next = STATUS_BAD_OP;
            end
            default:     state_next = ST_RST;
          endcase
        end
      end
      ST_RST:  state_next = ST_INIT;
      ST_INIT: state_next = ST_WAIT;
      ST_WAIT: begin
        // completion is checked before expiry so it wins a same-cycle tie
        if (core_fin_store) begin
          state_next = (op_q == OP_STORE_THEN_LOAD) ? LD_RST : RESP;
        end else if (expired) begin
          state_next  = RESP;
          status_next = STATUS_TIMEOUT;
        end
      end
      LD_RST: begin
        // the load-reset pulse was suppressed on entry when the buffer was empty
        if (!core_load_reset) begin
          state_next  = RESP;
          status_next = STATUS_EMPTY;
        end else begin
          state_next = LD_INIT;
        end
      end
      LD_INIT: state_next = LD_ARM;
      LD_ARM:  state_next = LD_WAIT;
      LD_WAIT: begin
        if (core_idle) begin
          rep_next   = rep_cnt - 1'b1;
          state_next = (rep_cnt == REPEAT_WIDTH'(1)) ? RESP : LD_RST;
        end else if (expired) begin
          state_next  = RESP;
          status_next = STATUS_TIMEOUT;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      op_q             <= OP_STORE;
      rep_cnt          <= '0;
      out_en           <= 1'b0;
      resp_status      <= STATUS_OK;
      resp_words       <= '0;
      core_store_reset <= 1'b0;
      core_store_init  <= 1'b0;
      core_load_reset  <= 1'b0;
      core_load_init   <= 1'b0;
    end else begin
      state            <= state_next;
      op_q             <= op_next;
      rep_cnt          <= rep_next;
      out_en           <= 1'b1;
      core_store_reset <= (state_next == ST_RST);
      core_store_init  <= (state_next == ST_INIT);
      core_load_reset  <= (state_next == LD_RST) && (core_store_words != '0);
      core_load_init   <= (state_next == LD_INIT);
      if ((state_next == RESP) && (state != RESP)) begin
        resp_status <= status_next;
        resp_words  <= core_store_words;
      end
    end
  end

endmodule

// File: tb/tb_magic_streamer_sequencer.sv
// tb/tb_magic_streamer_sequencer.sv - scoreboard bench with a behavioural core model
module tb_magic_streamer_sequencer;

  localparam logic [1:0] S_OK = 2'd0, S_EMPTY = 2'd1, S_TIMEOUT = 2'd2, S_BAD = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_repeat = 8'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_status;
  logic [10:0] resp_words;
  logic        busy;
  logic        core_store_reset, core_store_init, core_load_reset, core_load_init;
  logic        core_fin_store;
  logic [3:0]  core_state;
  logic [10:0] core_store_words;

  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;

  typedef struct {
    logic [1:0]  status;
    logic [10:0] words;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_sr = 0, n_si = 0, n_lr = 0, n_li = 0, excl_viol = 0;
  int load_tlast_cnt = 0, load_word_cnt = 0;

  always #5 clk = ~clk;

  magic_streamer_sequencer #(
    .STORAGE_IDX_WIDTH(10),
    .STATE_BIT_WIDTH  (4),
    .REPEAT_WIDTH     (8),
    .TIMEOUT_WIDTH    (24),
    .TIMEOUT_CYCLES   (24'd20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_repeat      (cmd_repeat),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_status     (resp_status),
    .resp_words      (resp_words),
    .busy            (busy),
    .core_store_reset(core_store_reset),
    .core_store_init (core_store_init),
    .core_load_reset (core_load_reset),
    .core_load_init  (core_load_init),
    .core_fin_store  (core_fin_store),
    .core_state      (core_state),
    .core_store_words(core_store_words)
  );

  // behavioural streamer core: counts stored words, replays them one per cycle
  logic [10:0] m_idx;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_state       <= 4'd0;
      core_store_words <= 11'd0;
      core_fin_store   <= 1'b0;
      m_idx            <= 11'd0;
    end else begin
      core_fin_store <= 1'b0;
      if (core_store_reset) core_store_words <= 11'd0;
      if (core_store_init)  core_state <= 4'd1;
      if (core_load_reset)  m_idx <= 11'd0;
      if (core_load_init)   core_state <= 4'd2;
      if (core_state == 4'd1 && s_tvalid) begin
        core_store_words <= core_store_words + 11'd1;
        if (s_tlast) begin
          core_fin_store <= 1'b1;
          core_state     <= 4'd0;
        end
      end
      if (core_state == 4'd2) begin
        load_word_cnt <= load_word_cnt + 1;
        m_idx         <= m_idx + 11'd1;
        if (m_idx == core_store_words - 11'd1) begin
          load_tlast_cnt <= load_tlast_cnt + 1;
          core_state     <= 4'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_sr += int'(core_store_reset);
    n_si += int'(core_store_init);
    n_lr += int'(core_load_reset);
    n_li += int'(core_load_init);
    if (int'(core_store_reset) + int'(core_store_init) + int'(core_load_reset) + int'(core_load_init) > 1)
      excl_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] rep, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_repeat = rep;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, busy, resp_valid, core_store_reset, core_store_init, core_load_reset,
         core_load_init, resp_status, resp_words} !== 20'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%b ready=%b valid=%b status=%0d words=%0d expected all 0",
               busy, cmd_ready, resp_valid, resp_status, resp_words);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_load_empty();
    bit ok;
    exp_t e;
    sb.push_back('{S_EMPTY, 11'd0});
    issue_cmd(2'd1, 8'd1, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL empty_accept: got no cmd_ready expected ready");
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_resp_latency: got resp_valid=%b expected 1 in cycle 2", resp_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_status !== e.status || resp_words !== e.words) begin
      n_errors++;
      $display("FAIL empty_resp: got status=%0d words=%0d expected status=%0d words=%0d",
               resp_status, resp_words, e.status, e.words);
    end
    n_checks++;
    if (n_lr !== 0 || n_li !== 0) begin
      n_errors++;
      $display("FAIL empty_no_pulses: got load_reset=%0d load_init=%0d expected 0 0", n_lr, n_li);
    end
    finish_resp();
    n_checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_handshake: got valid=%b ready=%b expected 0 1", resp_valid, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit stuck_ok;
    exp_t e;
    sb.push_back('{S_TIMEOUT, 11'd0});
    issue_cmd(2'd2, 8'd1, ok);
    repeat (21) tick();
    n_checks++;
    if (!ok || resp_valid !== 1'b0 || core_state !== 4'd1) begin
      n_errors++;
      $display("FAIL timeout_early: got ok=%b valid=%b core_state=%0d expected 1 0 1", ok, resp_valid, core_state);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_latency: got resp_valid=%b expected 1 after 20 wait cycles", resp_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_status !== e.status || resp_words !== e.words) begin
      n_errors++;
      $display("FAIL timeout_resp: got status=%0d words=%0d expected status=%0d words=%0d",
               resp_status, resp_words, e.status, e.words);
    end
    finish_resp();
    stuck_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready !== 1'b0 || busy !== 1'b0) stuck_ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!stuck_ok) begin
      n_errors++;
      $display("FAIL timeout_ready_held: got cmd_ready high or busy while core busy expected ready=0 busy=0");
    end
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_recover_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_store();
    bit ok;
    exp_t e;
    sb.push_back('{S_OK, 11'd5});
    issue_cmd(2'd0, 8'd1, ok);
    n_checks++;
    if (!ok || {core_store_reset, core_store_init, core_load_reset, core_load_init} !== 4'b1000) begin
      n_errors++;
      $display("FAIL store_cycle1: got ok=%b pulses=%b expected 1 1000", ok,
               {core_store_reset, core_store_init, core_load_reset, core_load_init});
    end
    tick();
    n_checks++;
    if ({core_store_reset, core_store_init, core_load_reset, core_load_init} !== 4'b0100) begin
      n_errors++;
      $display("FAIL store_cycle2: got pulses=%b expected 0100",
               {core_store_reset, core_store_init, core_load_reset, core_load_init});
    end
    tick();
    s_tvalid = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      s_tlast = (w == 5);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || core_fin_store !== 1'b1) begin
      n_errors++;
      $display("FAIL store_fin_cycle: got valid=%b fin=%b expected 0 1", resp_valid, core_fin_store);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL store_resp_latency: got resp_valid=%b expected 1", resp_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_status !== e.status || resp_words !== e.words) begin
      n_errors++;
      $display("FAIL store_resp: got status=%0d words=%0d expected status=%0d words=%0d",
               resp_status, resp_words, e.status, e.words);
    end
    finish_resp();
  endtask

  task automatic test_load_replay();
    bit ok;
    bit got;
    exp_t e;
    int li0, tl0, wc0;
    li0 = n_li;
    tl0 = load_tlast_cnt;
    wc0 = load_word_cnt;
    sb.push_back('{S_OK, 11'd5});
    issue_cmd(2'd1, 8'd3, ok);
    n_checks++;
    if (!ok || {core_store_reset, core_store_init, core_load_reset, core_load_init} !== 4'b0010) begin
      n_errors++;
      $display("FAIL load_cycle1: got ok=%b pulses=%b expected 1 0010", ok,
               {core_store_reset, core_store_init, core_load_reset, core_load_init});
    end
    tick();
    n_checks++;
    if ({core_store_reset, core_store_init, core_load_reset, core_load_init} !== 4'b0001) begin
      n_errors++;
      $display("FAIL load_cycle2: got pulses=%b expected 0001",
               {core_store_reset, core_store_init, core_load_reset, core_load_init});
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL load_resp_wait: got no response in 200 cycles expected one");
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_status !== e.status || resp_words !== e.words) begin
      n_errors++;
      $display("FAIL load_resp: got status=%0d words=%0d expected status=%0d words=%0d",
               resp_status, resp_words, e.status, e.words);
    end
    n_checks++;
    if (n_li - li0 !== 3 || load_tlast_cnt - tl0 !== 3 || load_word_cnt - wc0 !== 15) begin
      n_errors++;
      $display("FAIL load_replay_counts: got inits=%0d tlasts=%0d words=%0d expected 3 3 15",
               n_li - li0, load_tlast_cnt - tl0, load_word_cnt - wc0);
    end
    finish_resp();
  endtask

  task automatic test_bad_op();
    bit ok;
    bit stable;
    exp_t e;
    int p0;
    p0 = n_sr + n_si + n_lr + n_li;
    sb.push_back('{S_BAD, 11'd5});
    issue_cmd(2'd3, 8'd0, ok);
    n_checks++;
    if (!ok || resp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL badop_latency: got ok=%b valid=%b expected 1 1", ok, resp_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (resp_status !== e.status || resp_words !== e.words) begin
      n_errors++;
      $display("FAIL badop_resp: got status=%0d words=%0d expected status=%0d words=%0d",
               resp_status, resp_words, e.status, e.words);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_status !== e.status || cmd_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_errors++;
      $display("FAIL badop_backpressure: got valid=%b status=%0d expected held 1 %0d", resp_valid, resp_status, e.status);
    end
    n_checks++;
    if (n_sr + n_si + n_lr + n_li - p0 !== 0) begin
      n_errors++;
      $display("FAIL badop_no_pulses: got %0d pulses expected 0", n_sr + n_si + n_lr + n_li - p0);
    end
    finish_resp();
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL badop_next_ready: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue_cmd(2'd1, 8'd3, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok || busy !== 1'b1 || core_state !== 4'd2) begin
      n_errors++;
      $display("FAIL midreset_setup: got ok=%b busy=%b core_state=%0d expected 1 1 2", ok, busy, core_state);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy, resp_valid, core_store_reset, core_store_init, core_load_reset,
         core_load_init, resp_status, resp_words} !== 20'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got busy=%b ready=%b valid=%b expected all 0", busy, cmd_ready, resp_valid);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_release: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_empty();
    test_timeout();
    test_store();
    test_load_replay();
    test_bad_op();
    test_reset_mid();
    n_checks++;
    if (excl_viol !== 0 || sb.size() !== 0) begin
      n_errors++;
      $display("FAIL exclusivity_and_queue: got overlaps=%0d pending=%0d expected 0 0", excl_viol, sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
